// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state and direction encodings for the cnt_timer slice.
// Imported by cnt_timer and cnt_prescaler.
package cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: reloadable down-counter giving one tick every div+1 ce cycles.
// Ports: clk, rst_n, clr (restart at 0), ce (advance), div (reload), tick (pre_cnt == 0).
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 ce,
    input  logic [PRE_WIDTH-1:0] div,
    output logic                 tick
);

    logic [PRE_WIDTH-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (ce) begin
            if (pre_cnt == '0) begin
                pre_cnt <= div;
            end else begin
                pre_cnt <= pre_cnt - PRE_WIDTH'(1);
            end
        end
    end

    assign tick = (pre_cnt == '0);

endmodule

// File: rtl/cnt_timer.sv
// cnt_timer: up/down, one-shot/periodic timer with shadowed reload and registered tc.
// Ports: clk, rst_n, start, stop, ce, dir, oneshot, d, pre_div -> q, tc, busy, done.
// Optional prescaler enabled by defining CNT_TIMER_PRESCALE_EN.
module cnt_timer
    import cnt_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RST_VLU   = '0,
    parameter int               PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 ce,
    input  logic                 dir,
    input  logic                 oneshot,
    input  logic [WIDTH-1:0]     d,
    input  logic [PRE_WIDTH-1:0] pre_div,
    output logic [WIDTH-1:0]     q,
    output logic                 tc,
    output logic                 busy,
    output logic                 done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic             dir_r, dir_n;
    logic             oneshot_r, oneshot_n;
    logic             tc_n;
    logic             pre_term;
    logic             tick;
    logic             at_term;

`ifdef CNT_TIMER_PRESCALE_EN
    cnt_prescaler #(
        .PRE_WIDTH(PRE_WIDTH)
    ) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start && !stop),
        .ce   (ce && (state == ST_RUN)),
        .div  (pre_div),
        .tick (pre_term)
    );
`else
    logic unused_pre_div;
    assign unused_pre_div = ^pre_div;
    assign pre_term       = 1'b1;
`endif

    assign tick    = (state == ST_RUN) && ce && pre_term;
    assign at_term = (dir_r == DIR_UP) ? (q == shadow) : (q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            q         <= RST_VLU;
            tc        <= 1'b0;
            shadow    <= '0;
            dir_r     <= 1'b0;
            oneshot_r <= 1'b0;
        end else begin
            state     <= state_n;
            q         <= q_n;
            tc        <= tc_n;
            shadow    <= shadow_n;
            dir_r     <= dir_n;
            oneshot_r <= oneshot_n;
        end
    end

    always_comb begin
        state_n   = state;
        q_n       = q;
        tc_n      = 1'b0;
        shadow_n  = shadow;
        dir_n     = dir_r;
        oneshot_n = oneshot_r;
        // stop beats start; a stop alone outside RUN is ignored
        if (stop && (start || (state == ST_RUN))) begin
            state_n = ST_IDLE;
        end else if (start) begin
            state_n   = ST_RUN;
            shadow_n  = d;
            dir_n     = dir;
            oneshot_n = oneshot;
            q_n       = (dir == DIR_DOWN) ? d : '0;
        end else if (tick) begin
            if (at_term) begin
                tc_n = 1'b1;
                if (oneshot_r) begin
                    state_n = ST_DONE;
                end else begin
                    // reload latched only at the period boundary
                    shadow_n = d;
                    q_n      = (dir_r == DIR_UP) ? '0 : d;
                end
            end else if (dir_r == DIR_UP) begin
                q_n = q + WIDTH'(1);
            end else begin
                q_n = q - WIDTH'(1);
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_cnt_timer.sv
// tb_cnt_timer: directed and random stimulus against a period/phase model of cnt_timer.
// Expected outputs are queued per clock and compared by an independent monitor.
module tb_cnt_timer;

    localparam int         W   = 8;
    localparam int         PW  = 8;
    localparam logic [W-1:0] RST = 8'hA5;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ce = 1'b0;
    logic          dir = 1'b0;
    logic          oneshot = 1'b0;
    logic [W-1:0]  d = '0;
    logic [PW-1:0] pre_div = '0;
    logic [W-1:0]  q;
    logic          tc;
    logic          busy;
    logic          done;

    int errs = 0;
    int checks = 0;
    exp_t exp_q[$];

    // model: timer described by period length (shadow+1) and phase k
    int           m_state;  // 0 idle, 1 run, 2 done
    logic [W-1:0] m_shadow;
    logic [W-1:0] m_k;
    logic         m_dir;
    logic         m_os;
    logic         m_tc;
    logic         m_fresh;
    int           m_pre;

    cnt_timer #(
        .WIDTH    (W),
        .RST_VLU  (RST),
        .PRE_WIDTH(PW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .ce     (ce),
        .dir    (dir),
        .oneshot(oneshot),
        .d      (d),
        .pre_div(pre_div),
        .q      (q),
        .tc     (tc),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_state  = 0;
        m_shadow = '0;
        m_k      = '0;
        m_dir    = 1'b0;
        m_os     = 1'b0;
        m_tc     = 1'b0;
        m_fresh  = 1'b1;
        m_pre    = 0;
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        if (m_fresh) e.q = RST;
        else if (m_dir) e.q = m_k;
        else e.q = m_shadow - m_k;
        e.tc   = m_tc;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        return e;
    endfunction

    function automatic void m_step(logic st, logic sp, logic c, logic dr, logic os,
                                   logic [W-1:0] dv, logic [PW-1:0] pv);
        bit is_tick;
        m_tc = 1'b0;
        if (sp && (st || m_state == 1)) begin
            m_state = 0;
        end else if (st) begin
            m_state  = 1;
            m_shadow = dv;
            m_dir    = dr;
            m_os     = os;
            m_k      = '0;
            m_pre    = 0;
            m_fresh  = 1'b0;
        end else if (m_state == 1 && c) begin
`ifdef CNT_TIMER_PRESCALE_EN
            is_tick = (m_pre == 0);
            m_pre   = is_tick ? int'(pv) : m_pre - 1;
`else
            is_tick = 1'b1;
`endif
            if (is_tick) begin
                if (m_k == m_shadow) begin
                    m_tc = 1'b1;
                    if (m_os) begin
                        m_state = 2;
                    end else begin
                        m_shadow = dv;
                        m_k      = '0;
                    end
                end else begin
                    m_k = m_k + 1'b1;
                end
            end
        end
    endfunction

    task automatic step(input logic st, input logic sp, input logic c, input logic dr,
                        input logic os, input logic [W-1:0] dv, input logic [PW-1:0] pv);
        @(negedge clk);
        #1;
        start   = st;
        stop    = sp;
        ce      = c;
        dir     = dr;
        oneshot = os;
        d       = dv;
        pre_div = pv;
        m_step(st, sp, c, dr, os, dv, pv);
        exp_q.push_back(m_out());
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        ce    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_q", 16'(q), 16'(RST));
        chk("async_rst_busy", 16'(busy), 16'd0);
        chk("async_rst_done", 16'(done), 16'd0);
        chk("async_rst_tc", 16'(tc), 16'd0);
        m_reset();
        #1 rst_n = 1'b1;
        ce = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q", 16'(q), 16'(e.q));
                chk("tc", 16'(tc), 16'(e.tc));
                chk("busy", 16'(busy), 16'(e.busy));
                chk("done", 16'(done), 16'(e.done));
            end
        end
    end

    initial begin
        m_reset();
        #12;
        chk("reset_q", 16'(q), 16'(RST));
        chk("reset_tc", 16'(tc), 16'd0);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_done", 16'(done), 16'd0);
        rst_n = 1'b1;

        // down periodic d=3
        step(1, 0, 1, 0, 0, 3, 0);
        repeat (10) step(0, 0, 1, 0, 0, 3, 0);

        // up one-shot d=2, then restart
        step(1, 0, 1, 1, 1, 2, 0);
        repeat (6) step(0, 0, 1, 1, 1, 2, 0);
        step(1, 0, 1, 1, 1, 2, 0);
        repeat (2) step(0, 0, 1, 1, 1, 2, 0);

        // shadow reload: d changes mid-period
        step(1, 0, 1, 0, 0, 5, 0);
        repeat (2) step(0, 0, 1, 0, 0, 5, 0);
        repeat (10) step(0, 0, 1, 0, 0, 1, 0);

        // stop at q=2 then hold
        step(1, 0, 1, 0, 0, 5, 0);
        repeat (3) step(0, 0, 1, 0, 0, 5, 0);
        step(0, 1, 1, 0, 0, 5, 0);
        repeat (10) step(0, 0, 1, 0, 0, 5, 0);
        // start and stop together
        step(1, 1, 1, 0, 0, 4, 0);
        repeat (2) step(0, 0, 1, 0, 0, 4, 0);
        // start coincident with terminal tick
        step(1, 0, 1, 0, 0, 2, 0);
        repeat (2) step(0, 0, 1, 0, 0, 2, 0);
        step(1, 0, 1, 0, 0, 2, 0);
        repeat (3) step(0, 0, 1, 0, 0, 2, 0);

        // d=0 in both directions
        step(1, 0, 1, 1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);

        // ce gating, then async reset at q=4
        step(1, 0, 1, 0, 0, 7, 0);
        step(0, 0, 1, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 1, 0, 0, 7, 0);
        step(0, 0, 1, 0, 0, 7, 0);
        pulse_reset();
        repeat (2) step(0, 0, 1, 0, 0, 7, 0);

`ifdef CNT_TIMER_PRESCALE_EN
        step(1, 0, 1, 0, 0, 1, 2);
        repeat (14) step(0, 0, 1, 0, 0, 1, 2);
        step(1, 0, 1, 0, 0, 1, 0);
        repeat (8) step(0, 0, 1, 0, 0, 1, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(11) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                 W'($urandom_range(6)), PW'($urandom_range(3)));
        end

        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
